alu_bank_responder: RTL and testbench



---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_bank_responder_if.sv | 15 +
 rtl/alu_bank.sv | 111 +++++++++++
 rtl/alu_bank_responder.sv | 27 ++
 tb/tb_alu_bank_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-bank ALU responder: command/response encodings,
// request/response packets and the per-bank FSM state.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;

  typedef enum logic [1:0] {
    NOP = 2'd0,
    ADD = 2'd1,
    SUB = 2'd2,
    SHL = 2'd3
  } command_names_t;

  typedef enum logic [1:0] {
    NO_RESPONSE = 2'd0,
    SUCCESS     = 2'd1,
    OVERFLOW    = 2'd2,
    UNDERFLOW   = 2'd3
  } response_names_t;

  typedef struct packed {
    command_names_t        command;
    logic [ALU_DATA_W-1:0] data1;
    logic [ALU_DATA_W-1:0] data2;
  } input_packet_t;

  typedef struct packed {
    logic [ALU_DATA_W-1:0] data;
    response_names_t       response;
  } output_packet_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } bank_state_t;

endpackage

// File: rtl/alu_bank_responder_if.sv
// Request/response packet bundle between the ALU initiator (master) and the
// bank responder (slave); one packet slot per bank.
interface alu_bank_responder_if
  import alu_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4
);

  input_packet_t  input_packet  [NUM_BANKS];
  output_packet_t output_packet [NUM_BANKS];

  modport master (output input_packet, input output_packet);
  modport slave  (input input_packet, output output_packet);

endinterface

// File: rtl/alu_bank.sv
// One ALU bank: IDLE/BUSY/RESPOND FSM, request latch, latency counter and datapath.
// With ALU_CMD_LATENCY_EN defined, SHL runs LATENCY+2 cycles; otherwise all commands use LATENCY.
module alu_bank
  import alu_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DATA_W  = ALU_DATA_W
) (
  input  logic           clock,
  input  logic           reset,
  input  input_packet_t  req_i,
  output output_packet_t rsp_o
);

  // Wide enough for LATENCY+1 at the top of the legal LATENCY range.
  localparam int unsigned CNT_W = 9;
  localparam logic [CNT_W-1:0] LOAD_BASE = CNT_W'(LATENCY - 1);
`ifdef ALU_CMD_LATENCY_EN
  localparam logic [CNT_W-1:0] LOAD_SHL = CNT_W'(LATENCY + 1);
`endif

  bank_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_load_d;
  command_names_t  cmd_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] data_q;
  response_names_t resp_q;

  logic [DATA_W-1:0]   res_data_d;
  response_names_t     res_resp_d;
  logic [DATA_W:0]     sum_w;
  logic [2*DATA_W-1:0] shl_w;

  always_comb begin
`ifdef ALU_CMD_LATENCY_EN
    cnt_load_d = (req_i.command == SHL) ? LOAD_SHL : LOAD_BASE;
`else
    cnt_load_d = LOAD_BASE;
`endif
  end

  always_comb begin
    sum_w      = {1'b0, op1_q} + {1'b0, op2_q};
    shl_w      = (2*DATA_W)'(op1_q) << op2_q[4:0];
    res_data_d = '0;
    res_resp_d = SUCCESS;
    case (cmd_q)
      ADD: begin
        res_data_d = sum_w[DATA_W-1:0];
        if (sum_w[DATA_W]) res_resp_d = OVERFLOW;
      end
      SUB: begin
        res_data_d = op1_q - op2_q;
        if (op2_q > op1_q) res_resp_d = UNDERFLOW;
      end
      SHL: begin
        res_data_d = shl_w[DATA_W-1:0];
        if (|shl_w[2*DATA_W-1:DATA_W]) res_resp_d = OVERFLOW;
      end
      default: begin
        res_data_d = '0;
        res_resp_d = SUCCESS;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cmd_q   <= NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      data_q  <= '0;
      resp_q  <= NO_RESPONSE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i.command != NOP) begin
            cmd_q   <= req_i.command;
            op1_q   <= req_i.data1;
            op2_q   <= req_i.data2;
            cnt_q   <= cnt_load_d;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            data_q  <= res_data_d;
            resp_q  <= res_resp_d;
            state_q <= RESPOND;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESPOND: begin
          // Data is held; only the response pulse is retired here.
          resp_q  <= NO_RESPONSE;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_o.data     = data_q;
  assign rsp_o.response = resp_q;

endmodule

// File: rtl/alu_bank_responder.sv
// Multi-bank ALU responder: NUM_BANKS independent alu_bank instances behind one
// packet interface. Optional macro ALU_CMD_LATENCY_EN is resolved inside alu_bank.
module alu_bank_responder
  import alu_pkg::*;
#(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned DATA_W    = ALU_DATA_W
) (
  input logic                  clock,
  input logic                  reset,
  alu_bank_responder_if.slave  packets
);

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    alu_bank #(
      .LATENCY (LATENCY),
      .DATA_W  (DATA_W)
    ) u_bank (
      .clock (clock),
      .reset (reset),
      .req_i (packets.input_packet[b]),
      .rsp_o (packets.output_packet[b])
    );
  end

endmodule

// File: tb/tb_alu_bank_responder.sv
// Randomised scoreboard bench for alu_bank_responder: a driver predicts each
// accepted request into per-bank queues, a negedge monitor checks every cycle.
module tb_alu_bank_responder;
  import alu_pkg::*;

  localparam int unsigned NB  = 4;
  localparam int unsigned LAT = 4;

  typedef struct {
    int unsigned     edge_no;
    logic [31:0]     data;
    response_names_t resp;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int unsigned edge_n = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  exp_t        exp_q   [NB][$];
  int unsigned free_at [NB];
  logic [31:0] last_data [NB];

  alu_bank_responder_if #(.NUM_BANKS(NB)) ifc ();

  alu_bank_responder #(
    .NUM_BANKS (NB),
    .LATENCY   (LAT),
    .DATA_W    (32)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .packets (ifc)
  );

  always #5 clock = ~clock;
  always @(posedge clock) edge_n = edge_n + 1;

  task automatic check(input string name, input int unsigned b,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s bank%0d edge%0d: got %08h expected %08h", name, b, edge_n, act, exp);
    end
  endtask

  // Reference arithmetic on 64-bit integers, straight from the command rules.
  function automatic void ref_op(input command_names_t c, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] r,
                                 output response_names_t s);
    longint unsigned wa;
    longint unsigned wide;
    logic [4:0] sh;
    wa = 64'(a);
    sh = d[4:0];
    r = '0;
    s = NO_RESPONSE;
    case (c)
      ADD: begin
        wide = wa + 64'(d);
        r = wide[31:0];
        s = (wide > 64'hFFFF_FFFF) ? OVERFLOW : SUCCESS;
      end
      SUB: begin
        r = a - d;
        s = (d > a) ? UNDERFLOW : SUCCESS;
      end
      SHL: begin
        wide = wa << sh;
        r = wide[31:0];
        s = ((wide >> 32) != 0) ? OVERFLOW : SUCCESS;
      end
      default: ;
    endcase
  endfunction

  function automatic int unsigned cmd_latency(input command_names_t c);
`ifdef ALU_CMD_LATENCY_EN
    return (c == SHL) ? LAT + 2 : LAT;
`else
    return (c == NOP) ? LAT : LAT;
`endif
  endfunction

  // Predict what the upcoming edge does with the current inputs, then advance.
  task automatic step();
    int unsigned e;
    int unsigned lat;
    input_packet_t p;
    logic [31:0] r;
    response_names_t s;
    e = edge_n + 1;
    for (int b = 0; b < NB; b++) begin
      if (reset) begin
        exp_q[b].delete();
        free_at[b] = e + 1;
      end else begin
        p = ifc.input_packet[b];
        if (p.command != NOP && e >= free_at[b]) begin
          lat = cmd_latency(p.command);
          ref_op(p.command, p.data1, p.data2, r, s);
          exp_q[b].push_back('{edge_no: e + lat, data: r, resp: s});
          free_at[b] = e + lat + 2;
        end
      end
    end
    @(negedge clock);
    #1;
  endtask

  task automatic set_req(input int b, input command_names_t c,
                         input logic [31:0] a, input logic [31:0] d);
    ifc.input_packet[b] = '{command: c, data1: a, data2: d};
  endtask

  task automatic all_nop(input int unsigned cycles);
    for (int b = 0; b < NB; b++) set_req(b, NOP, '0, '0);
    for (int unsigned i = 0; i < cycles; i++) step();
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 4))
      0: return 32'hFFFF_FFFF - $urandom_range(0, 7);
      1: return 32'(32'($urandom_range(0, 8)));
      2: return 32'h8000_0000 | $urandom_range(0, 3);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t ex;
    output_packet_t o;
    for (int b = 0; b < NB; b++) begin
      o = ifc.output_packet[b];
      if (reset) begin
        last_data[b] = '0;
        check("reset_resp", b, 32'(o.response), 32'(NO_RESPONSE));
        check("reset_data", b, o.data, '0);
      end else if (exp_q[b].size() > 0 && exp_q[b][0].edge_no <= edge_n) begin
        ex = exp_q[b].pop_front();
        if (ex.edge_no != edge_n) begin
          check("late_resp_edge", b, edge_n, ex.edge_no);
        end else begin
          check("resp", b, 32'(o.response), 32'(ex.resp));
          check("data", b, o.data, ex.data);
          last_data[b] = ex.data;
        end
      end else begin
        check("idle_resp", b, 32'(o.response), 32'(NO_RESPONSE));
        check("hold_data", b, o.data, last_data[b]);
      end
    end
  end

  initial begin
    for (int b = 0; b < NB; b++) begin
      set_req(b, NOP, '0, '0);
      free_at[b] = 0;
      last_data[b] = '0;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    all_nop(20);

    set_req(0, ADD, 32'h5, 32'h7);
    step();
    all_nop(8);

    set_req(1, ADD, 32'hFFFF_FFFF, 32'h2); step(); all_nop(7);
    set_req(1, SUB, 32'h3, 32'h5);         step(); all_nop(7);
    set_req(1, SHL, 32'h8000_0001, 32'd1); step(); all_nop(7);
    set_req(1, SHL, 32'h0000_0001, 32'd31); step(); all_nop(7);

    set_req(0, ADD, 32'h1234_0000, 32'h0000_5678);
    set_req(1, SUB, 32'h0000_0010, 32'h0000_0001);
    set_req(2, SHL, 32'h0F00_0001, 32'd4);
    set_req(3, ADD, 32'hFFFF_FFF0, 32'h0000_0020);
    step();
    step();
    for (int b = 0; b < NB; b++) ifc.input_packet[b].data1 = $urandom;
    step();
    step();
    all_nop(8);

    set_req(2, ADD, 32'd100, 32'd23);
    for (int i = 0; i < 17; i++) step();
    all_nop(8);

    set_req(3, ADD, 32'd9, 32'd9);
    set_req(0, SHL, 32'h0000_0003, 32'd2);
    set_req(1, ADD, 32'd1, 32'd2);
    step();
    set_req(3, NOP, '0, '0);
    step();
    reset = 1'b1;
    all_nop(1);
    reset = 1'b0;
    all_nop(6);
    set_req(0, SHL, 32'h0000_0003, 32'd2);
    set_req(1, ADD, 32'd1, 32'd2);
    step();
    all_nop(10);

    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NB; b++) begin
        if ($urandom_range(0, 2) == 0)
          set_req(b, command_names_t'($urandom_range(0, 3)), rand_operand(), rand_operand());
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;
    all_nop(20);

    for (int b = 0; b < NB; b++)
      check("queue_drained", b, exp_q[b].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
